// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: majority voter over three replicated lanes with per-lane
// error counting and a NORMAL/SUSPECT/FAULT lane-isolation state machine.
module tmr_fault_monitor #(
  parameter int WIDTH        = 8,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clr_fault,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] vote,
  output logic [2:0]       lane_err,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c,
  output logic             fault,
  output logic [1:0]       fault_lane,
  output logic             multi_err
);
  typedef enum logic [1:0] {NORMAL, SUSPECT, FAULT} state_t;
  localparam logic [7:0] THRESH = 8'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_nx;
  logic [7:0] consec, consec_nx;
  logic [1:0] susp_lane, susp_nx, fault_lane_nx;
  logic [WIDTH-1:0] maj, h_lo, h_hi, v;
  logic [2:0] err, h_mask;
  logic multi, single;
  logic [1:0] lane;
  logic [CNT_W-1:0] cnt [3];
  // In FAULT the lower-indexed healthy lane wins every disputed bit, so the
  // degraded vote is simply that lane's word.
  always_comb begin
    maj    = (a & b) | (a & c) | (b & c);
    h_lo   = fault_lane == 2'd1 ? b : a;
    h_hi   = fault_lane == 2'd3 ? b : c;
    h_mask = fault_lane == 2'd1 ? 3'b110 : fault_lane == 2'd2 ? 3'b101 : 3'b011;
    v      = state == FAULT ? h_lo : maj;
    err    = {c != v, b != v, a != v} | ((state == FAULT && h_lo != h_hi) ? h_mask : 3'b000);
    multi  = (err[0] & err[1]) | (err[0] & err[2]) | (err[1] & err[2]);
    single = |err & ~multi;
    lane   = err[0] ? 2'd1 : err[1] ? 2'd2 : 2'd3;
  end
  always_comb begin
    state_nx      = state;
    consec_nx     = consec;
    susp_nx       = susp_lane;
    fault_lane_nx = fault_lane;
    if (clr_fault) begin
      state_nx      = NORMAL;
      consec_nx     = 8'd0;
      fault_lane_nx = 2'd0;
    end else if (in_valid && state != FAULT) begin
      if (!single) begin
        state_nx  = NORMAL;
        consec_nx = 8'd0;
      end else if (state == SUSPECT && lane == susp_lane) begin
        consec_nx = consec + 8'd1;
        if (consec + 8'd1 == THRESH) begin
          state_nx      = FAULT;
          fault_lane_nx = lane;
        end
      end else begin
        state_nx  = SUSPECT;
        susp_nx   = lane;
        consec_nx = 8'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      consec     <= 8'd0;
      susp_lane  <= 2'd0;
      fault_lane <= 2'd0;
      out_valid  <= 1'b0;
      vote       <= '0;
      lane_err   <= 3'b000;
      multi_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      consec     <= consec_nx;
      susp_lane  <= susp_nx;
      fault_lane <= fault_lane_nx;
      out_valid  <= in_valid;
      multi_err  <= clr_fault ? 1'b0 : multi_err | (in_valid & multi);
      if (in_valid) begin
        vote     <= v;
        lane_err <= err;
      end
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt[i] <= '0;
      else if (clr_cnt) cnt[i] <= '0;
      else if (in_valid && err[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
    end
  end
  assign err_cnt_a = cnt[0];
  assign err_cnt_b = cnt[1];
  assign err_cnt_c = cnt[2];
  assign fault     = state == FAULT;
endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb_tmr_fault_monitor: directed self-checking bench for tmr_fault_monitor.
module tb_tmr_fault_monitor;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clr_fault = 1'b0, clr_cnt = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic out_valid, fault, multi_err;
  logic [7:0] vote, err_cnt_a, err_cnt_b, err_cnt_c;
  logic [2:0] lane_err;
  logic [1:0] fault_lane;
  int passed = 0, total = 0;

  tmr_fault_monitor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .clr_fault(clr_fault), .clr_cnt(clr_cnt), .out_valid(out_valid), .vote(vote),
    .lane_err(lane_err), .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b),
    .err_cnt_c(err_cnt_c), .fault(fault), .fault_lane(fault_lane), .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [7:0] ia, ib, ic, input logic cf, cc);
    @(negedge clk);
    in_valid = v; a = ia; b = ib; c = ic; clr_fault = cf; clr_cnt = cc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_vote", vote, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cnt_a", err_cnt_a, 0);
    @(negedge clk) rst_n = 1'b1;

    step(1, 8'h5A, 8'h5A, 8'h5A, 0, 0);
    chk("clean_vote", vote, 8'h5A);
    chk("clean_valid", out_valid, 1);
    chk("clean_lane_err", lane_err, 3'b000);
    chk("clean_cnt_a", err_cnt_a, 0);
    step(0, 8'hFF, 8'h00, 8'h11, 0, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_vote_hold", vote, 8'h5A);

    step(1, 8'h01, 8'h02, 8'h00, 0, 0);
    chk("multi_vote", vote, 8'h00);
    chk("multi_lane_err", lane_err, 3'b011);
    chk("multi_flag", multi_err, 1);
    chk("multi_no_fault", fault, 0);
    chk("multi_cnt_b", err_cnt_b, 1);
    step(1, 8'h5A, 8'h5A, 8'h5A, 1, 1);
    chk("clrf_multi", multi_err, 0);
    chk("clrc_cnt_a", err_cnt_a, 0);

    for (int i = 0; i < 3; i++) step(1, 8'h00, 8'h10, 8'h00, 0, 0);
    step(1, 8'h00, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h00, 8'h10, 8'h00, 0, 0);
    chk("b_interrupted_fault", fault, 0);
    chk("b_interrupted_cnt", err_cnt_b, 6);

    for (int i = 0; i < 4; i++) begin
      step(1, 8'h00, 8'hFF, 8'hFF, 0, 0);
      chk("a_bad_vote", vote, 8'hFF);
      if (i == 2) chk("a_bad_pre_fault", fault, 0);
    end
    chk("a_fault", fault, 1);
    chk("a_fault_lane", fault_lane, 1);
    chk("a_cnt", err_cnt_a, 4);

    step(1, 8'h0F, 8'h0F, 8'h3C, 0, 0);
    chk("deg_vote", vote, 8'h0F);
    chk("deg_lane_err", lane_err, 3'b110);
    chk("deg_cnt_b", err_cnt_b, 7);
    chk("deg_fault_hold", fault_lane, 1);
    step(1, 8'hFF, 8'h33, 8'h33, 0, 0);
    chk("deg_agree_vote", vote, 8'h33);
    chk("deg_agree_err", lane_err, 3'b001);
    step(1, 8'h00, 8'h00, 8'h00, 1, 0);
    chk("clrf_fault", fault, 0);
    chk("clrf_lane", fault_lane, 0);
    chk("clrf_multi2", multi_err, 0);

    step(1, 8'h00, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 300; i++) step(1, 8'h00, 8'h00, 8'h01, 1, 0);
    chk("sat_cnt_c", err_cnt_c, 255);
    chk("sat_no_fault", fault, 0);
    step(1, 8'h00, 8'h00, 8'h01, 0, 1);
    chk("clrc_priority", err_cnt_c, 0);
    step(1, 8'h00, 8'h00, 8'h01, 0, 0);
    chk("cnt_c_restart", err_cnt_c, 1);

    step(1, 8'h00, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'h80, 8'h00, 8'h00, 0, 0);
    chk("pre_reset_fault", fault, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_fault", fault, 0);
    chk("async_rst_lane", fault_lane, 0);
    chk("async_rst_cnt_a", err_cnt_a, 0);
    chk("async_rst_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 8'h3C, 8'h3C, 8'h3C, 0, 0);
    chk("post_rst_vote", vote, 8'h3C);
    chk("post_rst_valid", out_valid, 1);
    step(1, 8'h00, 8'h00, 8'h01, 0, 0);
    chk("post_rst_normal", fault, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
